// File: rtl/tetris_input_pkg.sv
// Shared types and helpers for the Tetris button/switch front end.
// Optional auto-repeat is built when TETRIS_INPUT_AUTOREPEAT_EN is defined.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_t;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_ROTATE = 3;

    // Counter width large enough to hold the longest of the three intervals.
    function automatic int cnt_width(input int debounce, input int delay, input int rate);
        int longest;
        longest = debounce;
        if (delay > longest) longest = delay;
        if (rate > longest) longest = rate;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One input channel: synchroniser, debounce, press pulse and optional auto-repeat
// FSM (auto-repeat built only when TETRIS_INPUT_AUTOREPEAT_EN is defined).
module input_debounce_channel
    import tetris_input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic i_pixclk,
    input  logic i_reset,
    input  logic i_raw,
    input  logic i_enable,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic                   stable_q;
    logic                   synced;
    logic                   db_done;
    logic                   rise;
    logic                   fall;
    logic                   rpt_hit;
    logic                   pulse_d;
    btn_state_t             state_q;
    btn_state_t             state_d;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign db_done = (synced != stable_q) && (db_cnt == DB_LAST);
    assign rise    = db_done & ~stable_q;
    assign fall    = db_done & stable_q;
    assign o_level = stable_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Any cycle where synced agrees with the stable level restarts the count.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            db_cnt   <= '0;
            stable_q <= 1'b0;
        end else if (synced == stable_q) begin
            db_cnt <= '0;
        end else if (db_done) begin
            db_cnt   <= '0;
            stable_q <= ~stable_q;
        end else if (db_cnt != '1) begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic             rpt_ok;
    logic [CNT_W-1:0] rpt_cnt;

    assign rpt_ok  = i_repeat_en & i_enable;
    assign rpt_hit = rpt_ok && !fall &&
                     (((state_q == PRESSED) && (rpt_cnt == DELAY_LAST)) ||
                      ((state_q == REPEAT)  && (rpt_cnt == RATE_LAST)));

    // Held at zero while idle or repeat is not allowed; restarts after every pulse.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            rpt_cnt <= '0;
        end else if (fall || !rpt_ok || (state_q == IDLE) || rpt_hit) begin
            rpt_cnt <= '0;
        end else if (rpt_cnt != '1) begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_repeat_en;
    assign unused_repeat_en = i_repeat_en;
    assign rpt_hit          = 1'b0;
`endif

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = PRESSED;
            PRESSED: if (fall) state_d = IDLE;
                     else if (rpt_hit) state_d = REPEAT;
`ifdef TETRIS_INPUT_AUTOREPEAT_EN
            REPEAT:  if (fall) state_d = IDLE;
                     else if (!rpt_ok) state_d = PRESSED;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pulse_d = (rise | rpt_hit) & i_enable;
    end

    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            o_pulse <= 1'b0;
        end else begin
            o_pulse <= pulse_d;
        end
    end

endmodule

// File: rtl/tetris_input_frontend.sv
// Button/switch front end for the Tetris game logic: one debounce channel per move
// button plus one for the start switch. Auto-repeat via TETRIS_INPUT_AUTOREPEAT_EN.
module tetris_input_frontend
    import tetris_input_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic               i_pixclk,
    input  logic               i_reset,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic               i_start_sw,
    input  logic               i_enable,
    input  logic [NUM_BTN-1:0] i_repeat_mask,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_pulse,
    output logic               o_start_pulse,
    output logic               o_any_pulse
);

    if (NUM_BTN < 1)         begin : g_err_num   $error("NUM_BTN must be >= 1");         end
    if (SYNC_STAGES < 2)     begin : g_err_sync  $error("SYNC_STAGES must be >= 2");     end
    if (DEBOUNCE_CYCLES < 1) begin : g_err_db    $error("DEBOUNCE_CYCLES must be >= 1"); end
    if (REPEAT_DELAY < 1)    begin : g_err_delay $error("REPEAT_DELAY must be >= 1");    end
    if (REPEAT_RATE < 1)     begin : g_err_rate  $error("REPEAT_RATE must be >= 1");     end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        input_debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .i_pixclk   (i_pixclk),
            .i_reset    (i_reset),
            .i_raw      (i_btn[b]),
            .i_enable   (i_enable),
            .i_repeat_en(i_repeat_mask[b]),
            .o_level    (o_btn_level[b]),
            .o_pulse    (o_btn_pulse[b])
        );
    end

    // Start is never gated by the game-running enable and never repeats.
    logic unused_start_level;

    input_debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_start (
        .i_pixclk   (i_pixclk),
        .i_reset    (i_reset),
        .i_raw      (i_start_sw),
        .i_enable   (1'b1),
        .i_repeat_en(1'b0),
        .o_level    (unused_start_level),
        .o_pulse    (o_start_pulse)
    );

    assign o_any_pulse = |o_btn_pulse;

endmodule
